riscv_lsu: RTL

Load/store unit for the non-pipelined core's MEM stage. Sits directly downstream of the ALU: takes the ALU result as the effective address plus rs2 as store data. It runs one handshaked access on the data-memory bus, performs byte-lane steering and sign/zero extension, and reports completion, alignment faults and bus timeouts to the control unit.

---
 rtl/riscv_lsu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit for the MEM stage of a non-pipelined RISC-V core.
// Runs one handshaked access on the data-memory bus and performs byte-lane
// steering for stores plus lane extraction and sign/zero extension for loads.
// Alignment/illegal-funct3 faults skip the bus, and a wait counter turns a
// stalled bus into a bus error.
module riscv_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The timeout fires on the last allowed wait cycle, so mem_req stays high
  // for exactly MAX_WAIT cycles.
  localparam logic [15:0] LAST_WAIT = 16'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_lane;

  logic        fault;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Fault decode on the incoming request: bad alignment or illegal funct3.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fault = 1'b0;
    if (is_store) begin
      if (funct3 > 3'b010) fault = 1'b1;
    end else begin
      if (funct3 == 3'b011 || funct3[2:1] == 2'b11) fault = 1'b1;
    end
    if (funct3[1:0] == 2'b01 && addr[0])          fault = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) fault = 1'b1;
  end

  // Store lane steering: replicate data across lanes, strobe only the target bytes.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'd0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_c = {4{store_data[7:0]}};
          wstrb_c = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          wdata_c = {2{store_data[15:0]}};
          wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_c = store_data;
          wstrb_c = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction from the latched lane and width, then sign/zero extension.
  always_comb begin
    case (lat_lane)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Control FSM with registered bus signals, result and fault flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= 16'd0;
      lat_store  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_lane   <= 2'b00;
      load_data  <= 32'd0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_store  <= is_store;
            lat_funct3 <= funct3;
            lat_lane   <= addr[1:0];
            misaligned <= fault;
            bus_err    <= 1'b0;
            wait_cnt   <= 16'd0;
            if (fault) begin
              state     <= S_DONE;
              load_data <= 32'd0;
            end else begin
              state     <= S_BUS;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= wstrb_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        S_BUS: begin
          if (mem_ack) begin
            state     <= S_DONE;
            load_data <= lat_store ? 32'd0 : ld_ext;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'd0;
          end else if (wait_cnt == LAST_WAIT) begin
            state     <= S_DONE;
            bus_err   <= 1'b1;
            load_data <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done    = (state == S_DONE);
  assign busy    = (state != S_IDLE);
  assign mem_req = (state == S_BUS);

endmodule
